// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the serial FIR.
// Accumulator sizing and saturation bounds live here.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  function automatic int acc_width(
    input int bw,
    input int taps
  );
    return 2 * bw + $clog2(taps);
  endfunction

  function automatic logic signed [63:0] sat_max(
    input int bw
  );
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(
    input int bw
  );
    return -(64'sd1 <<< (bw - 1));
  endfunction

endpackage

// File: rtl/fir_serial_if.sv
// Sample stream handshake for the serial FIR.
// Master feeds samples and consumes results.
interface fir_serial_if #(
  parameter int bitwidth = 32
);

  logic                       in_valid;
  logic                       in_ready;
  logic signed [bitwidth-1:0] x;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [bitwidth-1:0] y;

  modport master (
    output in_valid,
    output x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y
  );

  modport slave (
    input  in_valid,
    input  x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y
  );

endinterface

// File: rtl/fir_mac.sv
// Registered multiply-accumulate with scaled, saturated result.
// Multiplier kept isolated so it can be pipelined later.
module fir_mac
  import fir_pkg::*;
#(
  parameter int bitwidth = 32,
  parameter int FRAC     = 16,
  parameter int TAPS     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       load,
  input  logic signed [bitwidth-1:0] a,
  input  logic signed [bitwidth-1:0] b,
  output logic signed [bitwidth-1:0] y
);

  localparam int AccW = acc_width(bitwidth, TAPS);
  localparam int PW   = 2 * bitwidth;

  localparam logic signed [AccW-1:0] MAX_A =
    AccW'(sat_max(bitwidth));
  localparam logic signed [AccW-1:0] MIN_A =
    AccW'(sat_min(bitwidth));

  logic signed [AccW-1:0]     acc;
  logic signed [AccW-1:0]     shifted;
  logic signed [PW-1:0]       prod;
  logic signed [bitwidth-1:0] sat;

  assign prod    = PW'(a) * PW'(b);
  assign shifted = acc >>> FRAC;

  // Floor scaling, then clamp to the sample range
  always_comb begin
    sat = shifted[bitwidth-1:0];
    if (shifted > MAX_A) begin
      sat = MAX_A[bitwidth-1:0];
    end else if (shifted < MIN_A) begin
      sat = MIN_A[bitwidth-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      y   <= '0;
    end else begin
      if (clr) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + AccW'(prod);
      end
      if (load) begin
        y <= sat;
      end
    end
  end

endmodule

// File: rtl/fir_serial.sv
// Time-multiplexed direct-form FIR, one MAC per cycle.
// Holds FSM, coefficient file and circular delay line.
module fir_serial
  import fir_pkg::*;
#(
  parameter int TAPS     = 8,
  parameter int bitwidth = 32,
  parameter int FRAC     = 16,
  parameter int AW       = $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  fir_serial_if.slave                bus,
  input  logic                       coef_we,
  input  logic [AW-1:0]              coef_addr,
  input  logic signed [bitwidth-1:0] coef_data,
  output logic                       busy
);

  localparam logic [AW:0]   TAPS_W = (AW + 1)'(TAPS);
  localparam logic [AW-1:0] TAPS_A = AW'(TAPS);
  localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);

  state_t state;
  state_t state_nx;

  logic signed [bitwidth-1:0] coef [TAPS];
  logic signed [bitwidth-1:0] dl   [TAPS];

  logic [AW:0]   cnt;
  logic [AW-1:0] head;
  logic [AW-1:0] k;
  logic [AW-1:0] idx;
  logic          accept;
  logic          mac_en;
  logic          fin;
  logic          coef_ok;

  assign bus.in_ready  = rst && (state == IDLE);
  assign bus.out_valid = (state == OUT);
  assign busy          = (state != IDLE);

  assign accept  = bus.in_valid && bus.in_ready;
  assign k       = cnt[AW-1:0];
  assign mac_en  = (state == MAC) && (cnt < TAPS_W);
  assign fin     = (state == MAC) && (cnt == TAPS_W);
  assign coef_ok = ({1'b0, coef_addr} < TAPS_W);

  // (head - k) mod TAPS without a divider
  always_comb begin
    idx = head - k;
    if (head < k) begin
      idx = head + (TAPS_A - k);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = MAC;
        end
      end
      MAC: begin
        if (fin) begin
          state_nx = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      head <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dl[i]   <= '0;
        coef[i] <= '0;
      end
    end else begin
      if (state == IDLE && coef_we && coef_ok) begin
        coef[coef_addr] <= coef_data;
      end
      if (accept) begin
        dl[head] <= bus.x;
        cnt      <= '0;
      end else if (mac_en) begin
        cnt <= cnt + (AW + 1)'(1);
      end
      if (fin) begin
        head <= (head == LAST) ? '0 : head + AW'(1);
      end
    end
  end

  fir_mac #(
    .bitwidth (bitwidth),
    .FRAC     (FRAC),
    .TAPS     (TAPS)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst),
    .clr   (accept),
    .en    (mac_en),
    .load  (fin),
    .a     (coef[k]),
    .b     (dl[idx]),
    .y     (bus.y)
  );

endmodule
